// File: rtl/mips_pkg.sv
`default_nettype none
// ---- mips_pkg: shared opcodes, ALU control codes and multicycle state encoding (rev 1.0) ----
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_FUNCT = 4'b0010;
    localparam logic [3:0] ALU_LUI   = 4'b0011;
    localparam logic [3:0] ALU_ORI   = 4'b0100;
    localparam logic [3:0] ALU_ANDI  = 4'b0101;
    localparam logic [3:0] ALU_XORI  = 4'b0111;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        BNEEX   = 4'd9,
        IEX     = 4'd10,
        IWB     = 4'd11,
        JEX     = 4'd12
    } state_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI,
            OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW: is_legal_op = 1'b1;
            default:                               is_legal_op = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_aludec.sv
`default_nettype none
// ---- imm_aludec: I-type opcode to {aluop, zeroext} (rev 1.0) ----
module imm_aludec
    import mips_pkg::*;
(
    input  logic [5:0] op,
    output logic [3:0] aluop,
    output logic       zeroext
);

    always_comb begin
        aluop   = ALU_ADD;
        zeroext = 1'b0;
        case (op)
            OP_LUI:  aluop = ALU_LUI;
            OP_ORI:  begin aluop = ALU_ORI;  zeroext = 1'b1; end
            OP_ANDI: begin aluop = ALU_ANDI; zeroext = 1'b1; end
            OP_XORI: begin aluop = ALU_XORI; zeroext = 1'b1; end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ---- mc_controller: multicycle MIPS control FSM with memory wait handshake (rev 1.0) ----
module mc_controller
    import mips_pkg::*;
#(
    parameter bit MEM_HS = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       zeroext,
    output logic [1:0] pcsrc,
    output logic [3:0] aluop,
    output logic       illegal,
    output logic [3:0] state
);

    state_t     cur;
    logic       mem_ok;
    logic       pcwrite, beq_br, bne_br;
    logic       ir_raw, mw_raw, rw_raw, ill_raw;
    logic [3:0] imm_aluop;
    logic       imm_zext;

    assign mem_ok = MEM_HS ? mem_ready : 1'b1;
    assign state  = cur;

    imm_aludec u_imm_aludec (
        .op      (op),
        .aluop   (imm_aluop),
        .zeroext (imm_zext)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur <= FETCH;
        end else begin
            case (cur)
                FETCH:   if (mem_ok) cur <= DECODE;
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW:                              cur <= MEMADR;
                        OP_RTYPE:                                  cur <= RTYPEEX;
                        OP_BEQ:                                    cur <= BEQEX;
                        OP_BNE:                                    cur <= BNEEX;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: cur <= IEX;
                        OP_J:                                      cur <= JEX;
                        default:                                   cur <= FETCH;
                    endcase
                end
                MEMADR:  cur <= (op == OP_SW) ? MEMWR : MEMRD;
                MEMRD:   if (mem_ok) cur <= MEMWB;
                MEMWR:   if (mem_ok) cur <= FETCH;
                RTYPEEX: cur <= RTYPEWB;
                IEX:     cur <= IWB;
                default: cur <= FETCH;
            endcase
        end
    end

    always_comb begin
        iord     = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluop    = ALU_ADD;
        zeroext  = 1'b0;
        pcsrc    = 2'b00;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        pcwrite  = 1'b0;
        beq_br   = 1'b0;
        bne_br   = 1'b0;
        ir_raw   = 1'b0;
        mw_raw   = 1'b0;
        rw_raw   = 1'b0;
        ill_raw  = 1'b0;
        case (cur)
            FETCH: begin
                alusrcb = 2'b01;
                ir_raw  = mem_ok;
                pcwrite = mem_ok;
            end
            DECODE: begin
                alusrcb = 2'b11;
                ill_raw = !is_legal_op(op);
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD:  iord = 1'b1;
            MEMWB: begin
                memtoreg = 1'b1;
                rw_raw   = 1'b1;
            end
            MEMWR: begin
                iord   = 1'b1;
                mw_raw = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALU_FUNCT;
            end
            RTYPEWB: begin
                regdst = 1'b1;
                rw_raw = 1'b1;
            end
            BEQEX, BNEEX: begin
                alusrca = 1'b1;
                aluop   = ALU_SUB;
                pcsrc   = 2'b01;
                beq_br  = (cur == BEQEX);
                bne_br  = (cur == BNEEX);
            end
            IEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = imm_aluop;
                zeroext = imm_zext;
            end
            // op is stable past FETCH, so re-decoding here holds the IEX values
            IWB: begin
                aluop   = imm_aluop;
                zeroext = imm_zext;
                rw_raw  = 1'b1;
            end
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign pcen     = reset & (pcwrite | (beq_br & zero) | (bne_br & ~zero));
    assign irwrite  = reset & ir_raw;
    assign memwrite = reset & mw_raw;
    assign regwrite = reset & rw_raw;
    assign illegal  = reset & ill_raw;

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ---- tb_mc_controller: randomized instruction-level checking of the multicycle control FSM (rev 1.0) ----
module tb_mc_controller;

    localparam logic [5:0] C_RTYPE = 6'b000000, C_J = 6'b000010, C_BEQ = 6'b000100;
    localparam logic [5:0] C_BNE = 6'b000101, C_ADDI = 6'b001000, C_ANDI = 6'b001100;
    localparam logic [5:0] C_ORI = 6'b001101, C_XORI = 6'b001110, C_LUI = 6'b001111;
    localparam logic [5:0] C_LW = 6'b100011, C_SW = 6'b101011;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       zero, mem_ready;
    logic       pcen, iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       zeroext, illegal;
    logic [3:0] aluop, state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mc_controller #(.MEM_HS(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pcen(pcen), .iord(iord), .irwrite(irwrite), .memwrite(memwrite),
        .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
        .alusrcb(alusrcb), .zeroext(zeroext), .pcsrc(pcsrc), .aluop(aluop),
        .illegal(illegal), .state(state)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Expected {zeroext, aluop} of an immediate instruction in its execute/writeback cycles
    function automatic logic [4:0] imm_expect(input logic [5:0] o);
        case (o)
            C_LUI:   return 5'b0_0011;
            C_ORI:   return 5'b1_0100;
            C_ANDI:  return 5'b1_0101;
            C_XORI:  return 5'b1_0111;
            default: return 5'b0_0000;
        endcase
    endfunction

    // Runs one instruction from its first FETCH cycle, aligned to a falling edge.
    // fw/mw: wait cycles in FETCH and in the data-memory phase; zsel<0 randomizes zero.
    // abort_at>=0 asserts reset during that cycle and checks the abort behaviour.
    task automatic run_instr(input logic [5:0] iop, input int fw, input int mw,
                             input int zsel, input int abort_at);
        bit   is_r, is_lw, is_sw, is_beq, is_bne, is_j, is_i, is_ill, taken, is_mem;
        int   len, s, irc, rwc, mwc, pcc, ilc;
        logic zarr[16];
        logic mr[16];
        is_r   = (iop == C_RTYPE);
        is_lw  = (iop == C_LW);
        is_sw  = (iop == C_SW);
        is_beq = (iop == C_BEQ);
        is_bne = (iop == C_BNE);
        is_j   = (iop == C_J);
        is_i   = (iop == C_ADDI) || (iop == C_ANDI) || (iop == C_ORI) ||
                 (iop == C_XORI) || (iop == C_LUI);
        is_ill = !(is_r || is_lw || is_sw || is_beq || is_bne || is_j || is_i);
        is_mem = is_lw || is_sw;
        if (is_lw)                       len = fw + mw + 5;
        else if (is_sw)                  len = fw + mw + 4;
        else if (is_r || is_i)           len = fw + 4;
        else if (is_beq || is_bne || is_j) len = fw + 3;
        else                             len = fw + 2;
        s = fw + 3;
        for (int c = 0; c < len; c++) begin
            zarr[c] = (zsel < 0) ? 1'($urandom % 2) : 1'(zsel);
            mr[c]   = 1'($urandom % 2);
            if (c < fw)  mr[c] = 1'b0;
            if (c == fw) mr[c] = 1'b1;
            if (is_mem && c >= s && c < s + mw) mr[c] = 1'b0;
            if (is_mem && c == s + mw)          mr[c] = 1'b1;
        end
        taken = is_j || (is_beq && zarr[fw+2]) || (is_bne && !zarr[fw+2]);
        irc = 0; rwc = 0; mwc = 0; pcc = 0; ilc = 0;
        for (int c = 0; c < len; c++) begin
            op        = iop;
            zero      = zarr[c];
            mem_ready = mr[c];
            #1;
            if (irwrite) begin
                irc++;
                check_eq("irwrite_cycle", c, fw);
            end
            if (regwrite) begin
                rwc++;
                check_eq("regwrite_cycle", c, len - 1);
                check_eq("memtoreg", memtoreg, is_lw);
                check_eq("regdst", regdst, is_r);
            end
            if (memwrite) begin
                mwc++;
                check_eq("memwrite_window", (c >= s) && (c <= s + mw), 1);
                check_eq("memwrite_iord", iord, 1);
            end
            if (pcen) begin
                pcc++;
                if (c == fw) begin
                    check_eq("fetch_srcb", alusrcb, 2'b01);
                    check_eq("fetch_pcsrc", pcsrc, 2'b00);
                end else begin
                    check_eq("pcen_cycle", c, fw + 2);
                    check_eq("branch_pcsrc", pcsrc, is_j ? 2'b10 : 2'b01);
                end
            end
            if (illegal) begin
                ilc++;
                check_eq("illegal_cycle", c, fw + 1);
            end
            if (is_i && (c == fw + 2 || c == fw + 3))
                check_eq("imm_alu", {zeroext, aluop}, imm_expect(iop));
            if (is_r && c == fw + 2)
                check_eq("rtype_aluop", aluop, 4'b0010);
            if ((is_beq || is_bne) && c == fw + 2)
                check_eq("branch_aluop", aluop, 4'b0001);
            if (c == abort_at) begin
                mem_ready = 1'b1;
                #1 reset = 1'b0;
                #1;
                check_eq("abort_state", state, mips_pkg::FETCH);
                check_eq("abort_strobes", {regwrite, memwrite, irwrite, pcen, illegal}, 5'b0);
                @(negedge clk);
                check_eq("reset_held_strobes", {regwrite, memwrite, irwrite, pcen}, 4'b0);
                reset = 1'b1;
                return;
            end
            @(negedge clk);
        end
        check_eq("irwrite_count", irc, 1);
        check_eq("regwrite_count", rwc, (is_r || is_i || is_lw) ? 1 : 0);
        check_eq("memwrite_count", mwc, is_sw ? mw + 1 : 0);
        check_eq("pcen_count", pcc, taken ? 2 : 1);
        check_eq("illegal_count", ilc, is_ill ? 1 : 0);
    endtask

    initial begin
        logic [5:0] ops[11];
        logic [5:0] rop;
        ops = '{C_RTYPE, C_J, C_BEQ, C_BNE, C_ADDI, C_ANDI, C_ORI, C_XORI, C_LUI, C_LW, C_SW};
        reset = 1'b0; op = C_RTYPE; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check_eq("reset_state", state, mips_pkg::FETCH);
        check_eq("reset_strobes", {pcen, irwrite, memwrite, regwrite, illegal}, 5'b0);
        @(negedge clk);
        reset = 1'b1;

        run_instr(C_LW,   2, 1, -1, -1);
        run_instr(C_SW,   0, 3, -1, -1);
        run_instr(C_BEQ,  0, 0,  1, -1);
        run_instr(C_BEQ,  1, 0,  0, -1);
        run_instr(C_BNE,  0, 0,  0, -1);
        run_instr(C_BNE,  0, 0,  1, -1);
        run_instr(C_ORI,  0, 0, -1, -1);
        run_instr(C_ADDI, 1, 0, -1, -1);
        run_instr(6'b111111, 0, 0, -1, -1);
        run_instr(C_J,    0, 0, -1, -1);
        run_instr(C_RTYPE, 0, 0, -1, 3);
        run_instr(C_RTYPE, 2, 0, -1, -1);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) == 0) rop = 6'($urandom);
            else                            rop = ops[$urandom_range(0, 10)];
            run_instr(rop, $urandom_range(0, 2), $urandom_range(0, 3), -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
